// File: rtl/porta_elevador_pkg.sv
// Shared types and elaboration helpers for the animated elevator door controller.
package porta_elevador_pkg;

  typedef enum logic [1:0] {
    FECHADA  = 2'd0,
    ABRINDO  = 2'd1,
    ABERTA   = 2'd2,
    FECHANDO = 2'd3
  } estado_t;

  // Counter width for a terminal count, never narrower than one bit.
  function automatic int largura_min1(input int valor);
    return (valor > 1) ? $clog2(valor) : 1;
  endfunction

  function automatic bit parametros_validos(input int num_leds, input int passo, input int espera);
    return (num_leds >= 4) && ((num_leds % 2) == 0) && (passo >= 1) && (espera >= 1);
  endfunction

endpackage

// File: rtl/porta_elevador_animada_temporizador.sv
// Free-running cycle timer with a one-cycle terminal pulse; wraps to zero on the terminal count.
module temporizador_passo
  import porta_elevador_pkg::*;
#(
  parameter int TERMINAL = 4
) (
  input  logic clock_in,
  input  logic reset,
  input  logic limpar,
  input  logic habilitar,
  output logic fim
);

  localparam int W = largura_min1(TERMINAL);
  localparam logic [W-1:0] ULTIMO = W'(TERMINAL - 1);

  logic [W-1:0] contagem;

  // fim must not depend on limpar: limpar is derived from the FSM next state, which consumes fim.
  assign fim = habilitar && (contagem == ULTIMO);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (limpar) begin
      contagem <= '0;
    end else if (habilitar) begin
      if (contagem == ULTIMO) begin
        contagem <= '0;
      end else begin
        contagem <= contagem + W'(1);
      end
    end
  end

endmodule

// File: rtl/porta_elevador_animada.sv
// Elevator door FSM with a symmetric LED bar that fills inward while closing and empties while opening.
module porta_elevador_animada
  import porta_elevador_pkg::*;
#(
  parameter int NUM_LEDS      = 10,
  parameter int PASSO_CICLOS  = 4,
  parameter int ESPERA_CICLOS = 16
) (
  input  logic                            clock_in,
  input  logic                            reset,
  input  logic                            pedido_abrir,
  input  logic                            pedido_fechar,
  input  logic                            obstrucao,
  input  logic                            modo_auto,
  output logic [NUM_LEDS-1:0]             leds,
  output logic                            port_a,
  output logic                            port_f,
  output logic                            em_movimento,
  output logic [$clog2(NUM_LEDS/2)-1:0]   nivel
);

  localparam int H  = NUM_LEDS / 2 - 1;
  localparam int NW = $clog2(NUM_LEDS / 2);
  localparam logic [NW-1:0] P_FECHADA = NW'(H);

  if (!parametros_validos(NUM_LEDS, PASSO_CICLOS, ESPERA_CICLOS)) begin : g_parametros_invalidos
    $error("porta_elevador_animada: NUM_LEDS must be even and >= 4, PASSO_CICLOS and ESPERA_CICLOS >= 1");
  end

  estado_t         estado, estado_next;
  logic [NW-1:0]   p, p_next;
  logic            fim_passo, fim_espera;
  logic            limpar_passo, habilitar_passo;
  logic            limpar_espera, habilitar_espera;
  logic            reverter;

  assign reverter = obstrucao || pedido_abrir;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      estado <= FECHADA;
      p      <= P_FECHADA;
    end else begin
      estado <= estado_next;
      p      <= p_next;
    end
  end

  always_comb begin
    estado_next = estado;
    p_next      = p;
    case (estado)
      FECHADA: begin
        if (pedido_abrir) begin
          estado_next = ABRINDO;
        end
      end
      ABRINDO: begin
        // The p<=1 guard also covers a reversal taken at p=0, which simply lands in ABERTA.
        if (fim_passo) begin
          if (p <= NW'(1)) begin
            p_next      = '0;
            estado_next = ABERTA;
          end else begin
            p_next = p - NW'(1);
          end
        end
      end
      ABERTA: begin
        if (!reverter && (pedido_fechar || fim_espera)) begin
          estado_next = FECHANDO;
        end
      end
      FECHANDO: begin
        if (reverter) begin
          estado_next = ABRINDO;
        end else if (fim_passo) begin
          p_next = p + NW'(1);
          if (p_next == P_FECHADA) begin
            estado_next = FECHADA;
          end
        end
      end
      default: begin
        estado_next = FECHADA;
        p_next      = P_FECHADA;
      end
    endcase
  end

  // Every state change restarts the step timer, so each motion phase starts from a full step.
  assign habilitar_passo  = (estado == ABRINDO) || (estado == FECHANDO);
  assign limpar_passo     = (estado_next != estado);
  assign habilitar_espera = (estado == ABERTA) && modo_auto && !reverter && !pedido_fechar;
  assign limpar_espera    = (estado != ABERTA) || reverter;

  temporizador_passo #(
    .TERMINAL (PASSO_CICLOS)
  ) u_passo (
    .clock_in  (clock_in),
    .reset     (reset),
    .limpar    (limpar_passo),
    .habilitar (habilitar_passo),
    .fim       (fim_passo)
  );

  temporizador_passo #(
    .TERMINAL (ESPERA_CICLOS)
  ) u_espera (
    .clock_in  (clock_in),
    .reset     (reset),
    .limpar    (limpar_espera),
    .habilitar (habilitar_espera),
    .fim       (fim_espera)
  );

  for (genvar gi = 0; gi <= H; gi++) begin : g_par
    assign leds[gi]              = (p >= NW'(gi));
    assign leds[NUM_LEDS-1-gi]   = (p >= NW'(gi));
  end

  assign port_a       = (estado == ABERTA);
  assign port_f       = (p == P_FECHADA);
  assign em_movimento = (estado == ABRINDO) || (estado == FECHANDO);
  assign nivel        = p;

endmodule

// File: tb/tb_porta_elevador_animada.sv
// Directed self-checking bench for porta_elevador_animada at default parameters.
module tb_porta_elevador_animada;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       pedido_abrir = 1'b0;
  logic       pedido_fechar = 1'b0;
  logic       obstrucao = 1'b0;
  logic       modo_auto = 1'b0;
  logic [9:0] leds;
  logic       port_a;
  logic       port_f;
  logic       em_movimento;
  logic [2:0] nivel;

  int vectors = 0;
  int miscompares = 0;

  // Expected bar pattern indexed by position p (hand-derived thermometer).
  logic [9:0] leds_tab [5];

  porta_elevador_animada #(
    .NUM_LEDS      (10),
    .PASSO_CICLOS  (4),
    .ESPERA_CICLOS (16)
  ) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .pedido_abrir  (pedido_abrir),
    .pedido_fechar (pedido_fechar),
    .obstrucao     (obstrucao),
    .modo_auto     (modo_auto),
    .leds          (leds),
    .port_a        (port_a),
    .port_f        (port_f),
    .em_movimento  (em_movimento),
    .nivel         (nivel)
  );

  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++; if (leds !== 10'h3FF) begin miscompares++; $display("FAIL reset_leds got %h exp %h", leds, 10'h3FF); end
    vectors++; if (port_f !== 1'b1) begin miscompares++; $display("FAIL reset_port_f got %b exp 1", port_f); end
    vectors++; if (port_a !== 1'b0) begin miscompares++; $display("FAIL reset_port_a got %b exp 0", port_a); end
    vectors++; if (em_movimento !== 1'b0) begin miscompares++; $display("FAIL reset_em_movimento got %b exp 0", em_movimento); end
    vectors++; if (nivel !== 3'd4) begin miscompares++; $display("FAIL reset_nivel got %0d exp 4", nivel); end
    reset = 1'b0;
    tick();
    pedido_fechar = 1'b1;
    tick();
    tick();
    pedido_fechar = 1'b0;
    vectors++; if (em_movimento !== 1'b0 || nivel !== 3'd4) begin
      miscompares++; $display("FAIL fechar_em_fechada em=%b nivel=%0d exp em=0 nivel=4", em_movimento, nivel);
    end
    $display("test_reset done");
  endtask

  task automatic test_abrir();
    int exp_n;
    pedido_abrir = 1'b1;
    tick();
    pedido_abrir = 1'b0;
    vectors++; if (em_movimento !== 1'b1 || nivel !== 3'd4 || port_f !== 1'b1) begin
      miscompares++; $display("FAIL abrir_inicio em=%b nivel=%0d port_f=%b exp 1/4/1", em_movimento, nivel, port_f);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_n = 4 - k / 4;
      vectors++; if (nivel !== 3'(exp_n)) begin miscompares++; $display("FAIL abrir_nivel k=%0d got %0d exp %0d", k, nivel, exp_n); end
      vectors++; if (leds !== leds_tab[exp_n]) begin miscompares++; $display("FAIL abrir_leds k=%0d got %b exp %b", k, leds, leds_tab[exp_n]); end
      vectors++; if (port_a !== (k == 16)) begin miscompares++; $display("FAIL abrir_port_a k=%0d got %b exp %b", k, port_a, (k == 16)); end
      vectors++; if (em_movimento !== (k < 16)) begin miscompares++; $display("FAIL abrir_em k=%0d got %b exp %b", k, em_movimento, (k < 16)); end
    end
    vectors++; if (leds !== 10'b1000000001) begin miscompares++; $display("FAIL abrir_leds_aberta got %b exp 1000000001", leds); end
    repeat (20) tick();
    vectors++; if (port_a !== 1'b1 || em_movimento !== 1'b0) begin
      miscompares++; $display("FAIL manual_fica_aberta port_a=%b em=%b exp 1/0", port_a, em_movimento);
    end
    $display("test_abrir done");
  endtask

  task automatic test_obstrucao();
    pedido_fechar = 1'b1;
    tick();
    pedido_fechar = 1'b0;
    vectors++; if (em_movimento !== 1'b1 || port_a !== 1'b0 || nivel !== 3'd0) begin
      miscompares++; $display("FAIL fechar_inicio em=%b port_a=%b nivel=%0d exp 1/0/0", em_movimento, port_a, nivel);
    end
    repeat (8) tick();
    vectors++; if (nivel !== 3'd2) begin miscompares++; $display("FAIL fechar_nivel2 got %0d exp 2", nivel); end
    obstrucao = 1'b1;
    tick();
    obstrucao = 1'b0;
    vectors++; if (nivel !== 3'd2 || em_movimento !== 1'b1) begin
      miscompares++; $display("FAIL obstr_reversao nivel=%0d em=%b exp 2/1", nivel, em_movimento);
    end
    repeat (3) tick();
    vectors++; if (nivel !== 3'd2) begin miscompares++; $display("FAIL obstr_mantem got %0d exp 2", nivel); end
    tick();
    vectors++; if (nivel !== 3'd1) begin miscompares++; $display("FAIL obstr_passo got %0d exp 1", nivel); end
    repeat (4) tick();
    vectors++; if (nivel !== 3'd0 || port_a !== 1'b1 || em_movimento !== 1'b0) begin
      miscompares++; $display("FAIL obstr_reaberta nivel=%0d port_a=%b em=%b exp 0/1/0", nivel, port_a, em_movimento);
    end
    $display("test_obstrucao done");
  endtask

  task automatic test_obstrucao_mantida();
    modo_auto = 1'b1;
    obstrucao = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k % 8 == 0) begin
        vectors++; if (port_a !== 1'b1) begin miscompares++; $display("FAIL obstr_mantida k=%0d port_a=%b exp 1", k, port_a); end
      end
    end
    obstrucao = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++; if (port_a !== (k < 16)) begin miscompares++; $display("FAIL auto_fecho k=%0d port_a=%b exp %b", k, port_a, (k < 16)); end
    end
    vectors++; if (em_movimento !== 1'b1 || nivel !== 3'd0) begin
      miscompares++; $display("FAIL auto_fecho_inicio em=%b nivel=%0d exp 1/0", em_movimento, nivel);
    end
    $display("test_obstrucao_mantida done");
  endtask

  task automatic test_back_to_back();
    int exp_n;
    repeat (8) tick();
    vectors++; if (nivel !== 3'd2) begin miscompares++; $display("FAIL b2b_nivel2 got %0d exp 2", nivel); end
    pedido_abrir = 1'b1;
    pedido_fechar = 1'b1;
    tick();
    vectors++; if (nivel !== 3'd2 || em_movimento !== 1'b1) begin
      miscompares++; $display("FAIL b2b_reversao nivel=%0d em=%b exp 2/1", nivel, em_movimento);
    end
    repeat (3) tick();
    vectors++; if (nivel !== 3'd2) begin miscompares++; $display("FAIL b2b_mantem got %0d exp 2", nivel); end
    tick();
    vectors++; if (nivel !== 3'd1) begin miscompares++; $display("FAIL b2b_passo got %0d exp 1", nivel); end
    repeat (4) tick();
    vectors++; if (port_a !== 1'b1 || nivel !== 3'd0) begin
      miscompares++; $display("FAIL b2b_aberta port_a=%b nivel=%0d exp 1/0", port_a, nivel);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      vectors++; if (port_a !== 1'b1) begin miscompares++; $display("FAIL b2b_ambos_aberta k=%0d port_a=%b exp 1", k, port_a); end
    end
    pedido_abrir = 1'b0;
    pedido_fechar = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++; if (port_a !== (k < 16)) begin miscompares++; $display("FAIL b2b_espera k=%0d port_a=%b exp %b", k, port_a, (k < 16)); end
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_n = k / 4;
      vectors++; if (nivel !== 3'(exp_n)) begin miscompares++; $display("FAIL fecho_nivel k=%0d got %0d exp %0d", k, nivel, exp_n); end
      vectors++; if (port_f !== (k == 16)) begin miscompares++; $display("FAIL fecho_port_f k=%0d got %b exp %b", k, port_f, (k == 16)); end
      vectors++; if (em_movimento !== (k < 16)) begin miscompares++; $display("FAIL fecho_em k=%0d got %b exp %b", k, em_movimento, (k < 16)); end
    end
    modo_auto = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    pedido_abrir = 1'b1;
    tick();
    pedido_abrir = 1'b0;
    repeat (8) tick();
    vectors++; if (nivel !== 3'd2 || em_movimento !== 1'b1) begin
      miscompares++; $display("FAIL mid_pre_reset nivel=%0d em=%b exp 2/1", nivel, em_movimento);
    end
    #1 reset = 1'b1;
    #1;
    vectors++; if (nivel !== 3'd4) begin miscompares++; $display("FAIL mid_reset_async nivel=%0d exp 4", nivel); end
    tick();
    vectors++; if (leds !== 10'h3FF) begin miscompares++; $display("FAIL mid_reset_leds got %h exp 3ff", leds); end
    vectors++; if (port_f !== 1'b1) begin miscompares++; $display("FAIL mid_reset_port_f got %b exp 1", port_f); end
    vectors++; if (nivel !== 3'd4) begin miscompares++; $display("FAIL mid_reset_nivel got %0d exp 4", nivel); end
    vectors++; if (em_movimento !== 1'b0) begin miscompares++; $display("FAIL mid_reset_em got %b exp 0", em_movimento); end
    reset = 1'b0;
    repeat (6) tick();
    vectors++; if (nivel !== 3'd4 || em_movimento !== 1'b0 || port_a !== 1'b0) begin
      miscompares++; $display("FAIL pos_reset nivel=%0d em=%b port_a=%b exp 4/0/0", nivel, em_movimento, port_a);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    leds_tab[0] = 10'b1000000001;
    leds_tab[1] = 10'b1100000011;
    leds_tab[2] = 10'b1110000111;
    leds_tab[3] = 10'b1111001111;
    leds_tab[4] = 10'b1111111111;
    test_reset();
    test_abrir();
    test_obstrucao();
    test_obstrucao_mantida();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
